// File: rtl/alu_cmd_sequencer.sv
// Initiator side of the ALU operand/result interface: one command in flight,
// operands held on alu_* for SETTLE cycles, result returned with its tag.

// state | meaning
// IDLE  | ready for a command; alu_* hold the last operands
// WAIT  | alu_* driven, settle counter running down to zero
// RESP  | result captured, rsp_valid high until the consumer takes it
module alu_cmd_sequencer #(
    parameter int WIDTH  = 32,
    parameter int OPW    = 4,
    parameter int TAGW   = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [OPW-1:0]   cmd_op,
    input  logic [TAGW-1:0]  cmd_tag,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_x,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_x,
    output logic [OPW-1:0]   rsp_op,
    output logic [TAGW-1:0]  rsp_tag,
    output logic             rsp_zero,
    output logic             busy,
    output logic [15:0]      done_count
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    if (SETTLE < 1) begin : g_bad_settle
        $error("alu_cmd_sequencer: SETTLE must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   settle_cnt;
    logic [TAGW-1:0] tag_q;
    logic            accept;

    assign cmd_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = WAIT;
            WAIT:    if (settle_cnt == '0) state_nxt = RESP;
            RESP:    if (rsp_valid && rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            tag_q      <= '0;
            settle_cnt <= '0;
            rsp_valid  <= 1'b0;
            rsp_x      <= '0;
            rsp_op     <= '0;
            rsp_tag    <= '0;
            rsp_zero   <= 1'b0;
            done_count <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a      <= cmd_a;
                        alu_b      <= cmd_b;
                        alu_op     <= cmd_op;
                        tag_q      <= cmd_tag;
                        settle_cnt <= CW'(SETTLE - 1);
                    end
                end
                WAIT: begin
                    // Terminal count: the ALU has had SETTLE cycles on stable operands.
                    if (settle_cnt == '0) begin
                        rsp_x     <= alu_x;
                        rsp_zero  <= (alu_x == '0);
                        rsp_op    <= alu_op;
                        rsp_tag   <= tag_q;
                        rsp_valid <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        done_count <= done_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
